// File: rtl/control_pb20000_if.sv
// Handshake/control bundle between the biquad sequencer and its datapath.
// master: sequencer side (drives selects/enables/status, receives tick/clear).
// slave: datapath/ADC/DAC side.
interface control_pb20000_if;
  logic       sample_tick;
  logic       clr_ovr;
  logic       en1;
  logic       en2;
  logic       en3;
  logic       en4;
  logic       en5;
  logic       en6;
  logic       en7;
  logic [2:0] selmuxS;
  logic [1:0] selmuxC;
  logic [2:0] selmuxZ;
  logic       busy;
  logic       yk_valid;
  logic       ovr;

  modport master (
    input  sample_tick, clr_ovr,
    output en1, en2, en3, en4, en5, en6, en7,
    output selmuxS, selmuxC, selmuxZ, busy, yk_valid, ovr
  );

  modport slave (
    output sample_tick, clr_ovr,
    input  en1, en2, en3, en4, en5, en6, en7,
    input  selmuxS, selmuxC, selmuxZ, busy, yk_valid, ovr
  );
endinterface

// File: rtl/control_pb20000.sv
// Sequencer for the 20 kHz low-pass biquad datapath: one sample tick runs C1..C5 then SHIFT.
// Latency: tick at edge t -> C1 outputs at t+1, yk_valid at t+1+5*STEP_CYCLES; all outputs registered.
// Backpressure: none; ticks outside IDLE are dropped and flagged in the sticky ovr bit.
module control_pb20000 #(
  parameter int STEP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  control_pb20000_if.master   bus
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C1    = 3'd1,
    C2    = 3'd2,
    C3    = 3'd3,
    C4    = 3'd4,
    C5    = 3'd5,
    SHIFT = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  // en_*[0] is en1 ... en_*[6] is en7
  logic [6:0]    en_q, en_d;
  logic [2:0]    sel_s_q, sel_s_d;
  logic [1:0]    sel_c_q, sel_c_d;
  logic [2:0]    sel_z_q, sel_z_d;
  logic          busy_q, busy_d;
  logic          ykv_q, ykv_d;
  logic          last_d;

  // Next state, step counter and overrun flag; outputs are decoded from the
  // next state so that the registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: if (bus.sample_tick) state_d = C1;
      C1, C2, C3, C4, C5: begin
        if (cnt_q == LAST) begin
          case (state_q)
            C1:      state_d = C2;
            C2:      state_d = C3;
            C3:      state_d = C4;
            C4:      state_d = C5;
            default: state_d = SHIFT;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Set beats clear: a dropped tick must never be lost to a simultaneous clear.
    if (bus.sample_tick && (state_q != IDLE)) ovr_d = 1'b1;
    else if (bus.clr_ovr)                     ovr_d = 1'b0;

    last_d  = (cnt_d == LAST);
    en_d    = '0;
    sel_s_d = '0;
    sel_c_d = '0;
    sel_z_d = '0;
    case (state_d)
      C1: begin sel_s_d = 3'd1; sel_c_d = 2'd0; sel_z_d = 3'd0; en_d[4] = last_d; end
      C2: begin sel_s_d = 3'd2; sel_c_d = 2'd1; sel_z_d = 3'd1; en_d[1] = last_d; end
      C3: begin sel_s_d = 3'd2; sel_c_d = 2'd2; sel_z_d = 3'd4; en_d[5] = last_d; end
      C4: begin sel_s_d = 3'd0; sel_c_d = 2'd2; sel_z_d = 3'd2; en_d[6] = last_d; end
      C5: begin sel_s_d = 3'd1; sel_c_d = 2'd3; sel_z_d = 3'd3; en_d[0] = last_d; end
      // f1<=f and f2<=f1 in the same edge so both shift from the old values
      SHIFT: begin en_d[2] = 1'b1; en_d[3] = 1'b1; end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    ykv_d  = (state_d == SHIFT);
  end

  // State and registered outputs; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      en_q    <= '0;
      sel_s_q <= '0;
      sel_c_q <= '0;
      sel_z_q <= '0;
      busy_q  <= 1'b0;
      ykv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      sel_s_q <= sel_s_d;
      sel_c_q <= sel_c_d;
      sel_z_q <= sel_z_d;
      busy_q  <= busy_d;
      ykv_q   <= ykv_d;
    end
  end

  assign bus.en1      = en_q[0];
  assign bus.en2      = en_q[1];
  assign bus.en3      = en_q[2];
  assign bus.en4      = en_q[3];
  assign bus.en5      = en_q[4];
  assign bus.en6      = en_q[5];
  assign bus.en7      = en_q[6];
  assign bus.selmuxS  = sel_s_q;
  assign bus.selmuxC  = sel_c_q;
  assign bus.selmuxZ  = sel_z_q;
  assign bus.busy     = busy_q;
  assign bus.yk_valid = ykv_q;
  assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_control_pb20000.sv
// Bench for control_pb20000: vector table at STEP_CYCLES=1, a STEP_CYCLES=3 run,
// and a behavioural biquad datapath closed around the sequencer.
module tb_control_pb20000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_pb20000_if if1 ();
  control_pb20000_if if2 ();

  control_pb20000 #(.STEP_CYCLES(1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1.master));
  control_pb20000 #(.STEP_CYCLES(3)) dut2 (.clk(clk), .reset(rst_n), .bus(if2.master));

  int checks = 0;
  int errors = 0;

  // observed word: {en7..en1, S, C, Z, busy, yk_valid, ovr}
  logic [17:0] obs1, obs2;
  assign obs1 = {if1.en7, if1.en6, if1.en5, if1.en4, if1.en3, if1.en2, if1.en1,
                 if1.selmuxS, if1.selmuxC, if1.selmuxZ, if1.busy, if1.yk_valid, if1.ovr};
  assign obs2 = {if2.en7, if2.en6, if2.en5, if2.en4, if2.en3, if2.en2, if2.en1,
                 if2.selmuxS, if2.selmuxC, if2.selmuxZ, if2.busy, if2.yk_valid, if2.ovr};

  // Expected word for step n (1..5) of the schedule; en only when lst is set.
  function automatic logic [17:0] cw(int n, logic lst, logic o);
    logic [6:0] en;
    logic [2:0] s;
    logic [1:0] c;
    logic [2:0] z;
    en = '0; s = '0; c = '0; z = '0;
    case (n)
      1: begin s = 3'd1; c = 2'd0; z = 3'd0; en = 7'b0010000; end
      2: begin s = 3'd2; c = 2'd1; z = 3'd1; en = 7'b0000010; end
      3: begin s = 3'd2; c = 2'd2; z = 3'd4; en = 7'b0100000; end
      4: begin s = 3'd0; c = 2'd2; z = 3'd2; en = 7'b1000000; end
      default: begin s = 3'd1; c = 2'd3; z = 3'd3; en = 7'b0000001; end
    endcase
    if (!lst) en = '0;
    return {en, s, c, z, 1'b1, 1'b0, o};
  endfunction

  function automatic logic [17:0] c1w(int n, logic o);
    return cw(n, 1'b1, o);
  endfunction

  function automatic logic [17:0] shw(logic o);
    return {7'b0001100, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1, o};
  endfunction

  function automatic logic [17:0] idw(logic o);
    return {17'd0, o};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Behavioural biquad datapath driven by dut1 (a1=a2=b0=0, b1=1).
  int a1 = 0, a2 = 0, b0 = 0, b1 = 1;
  int uk = 0;
  int f, f1, f2, ac1, ac2, ac3, y;
  int mul_s, coef, addend, prod;

  always_comb begin
    mul_s = 0; coef = 0; addend = 0;
    case (if1.selmuxS)
      3'd0: mul_s = f;
      3'd1: mul_s = f1;
      3'd2: mul_s = f2;
      default: mul_s = 0;
    endcase
    case (if1.selmuxC)
      2'd0: coef = a1;
      2'd1: coef = a2;
      2'd2: coef = b0;
      default: coef = b1;
    endcase
    case (if1.selmuxZ)
      3'd0: addend = uk;
      3'd1: addend = ac1;
      3'd2: addend = ac2;
      3'd3: addend = ac3;
      default: addend = 0;
    endcase
    prod = coef * mul_s + addend;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      f <= 0; f1 <= 0; f2 <= 0; ac1 <= 0; ac2 <= 0; ac3 <= 0; y <= 0;
    end else begin
      if (if1.en1) y   <= prod;
      if (if1.en2) f   <= prod;
      if (if1.en3) f1  <= f;
      if (if1.en4) f2  <= f1;
      if (if1.en5) ac1 <= prod;
      if (if1.en6) ac2 <= prod;
      if (if1.en7) ac3 <= prod;
    end
  end

  typedef struct {
    logic        rst;
    logic        tick;
    logic        clr;
    logic [17:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic t, logic c, logic [17:0] e);
    vec_t v;
    v.rst = r; v.tick = t; v.clr = c; v.exp = e;
    return v;
  endfunction

  task automatic run_tick(int val, int exp_y);
    bit seen;
    uk = val;
    if1.sample_tick = 1'b1;
    @(posedge clk); #1;
    if1.sample_tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (if1.yk_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk($sformatf("dp_ykvalid_u%0d", val), {31'd0, seen}, 32'd1);
    if (seen) chk($sformatf("dp_y_u%0d", val), y, exp_y);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if1.sample_tick = 1'b0; if1.clr_ovr = 1'b0;
    if2.sample_tick = 1'b0; if2.clr_ovr = 1'b0;

    // T1: reset and a single clean sequence
    vt.push_back(mk(0, 0, 0, idw(0)));
    vt.push_back(mk(0, 0, 0, idw(0)));
    vt.push_back(mk(1, 0, 0, idw(0)));
    vt.push_back(mk(1, 1, 0, c1w(1, 0)));
    vt.push_back(mk(1, 0, 0, c1w(2, 0)));
    vt.push_back(mk(1, 0, 0, c1w(3, 0)));
    vt.push_back(mk(1, 0, 0, c1w(4, 0)));
    vt.push_back(mk(1, 0, 0, c1w(5, 0)));
    vt.push_back(mk(1, 0, 0, shw(0)));
    vt.push_back(mk(1, 0, 0, idw(0)));
    // T4: tick while busy, clear, and set-vs-clear in one cycle
    vt.push_back(mk(1, 1, 0, c1w(1, 0)));
    vt.push_back(mk(1, 0, 0, c1w(2, 0)));
    vt.push_back(mk(1, 1, 0, c1w(3, 1)));
    vt.push_back(mk(1, 0, 0, c1w(4, 1)));
    vt.push_back(mk(1, 0, 1, c1w(5, 0)));
    vt.push_back(mk(1, 1, 1, shw(1)));
    vt.push_back(mk(1, 0, 1, idw(0)));
    // T5: tick in SHIFT dropped, tick in following IDLE accepted
    vt.push_back(mk(1, 1, 0, c1w(1, 0)));
    vt.push_back(mk(1, 0, 0, c1w(2, 0)));
    vt.push_back(mk(1, 0, 0, c1w(3, 0)));
    vt.push_back(mk(1, 0, 0, c1w(4, 0)));
    vt.push_back(mk(1, 0, 0, c1w(5, 0)));
    vt.push_back(mk(1, 0, 0, shw(0)));
    vt.push_back(mk(1, 1, 0, idw(1)));
    vt.push_back(mk(1, 1, 0, c1w(1, 1)));
    vt.push_back(mk(1, 0, 0, c1w(2, 1)));
    vt.push_back(mk(1, 0, 0, c1w(3, 1)));
    // T6: reset during C3, then a fresh full sequence
    vt.push_back(mk(0, 0, 0, idw(0)));
    vt.push_back(mk(0, 1, 0, idw(0)));
    vt.push_back(mk(1, 1, 0, c1w(1, 0)));
    vt.push_back(mk(1, 0, 0, c1w(2, 0)));
    vt.push_back(mk(1, 0, 0, c1w(3, 0)));
    vt.push_back(mk(1, 0, 0, c1w(4, 0)));
    vt.push_back(mk(1, 0, 0, c1w(5, 0)));
    vt.push_back(mk(1, 0, 0, shw(0)));
    vt.push_back(mk(1, 0, 0, idw(0)));

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst;
      if1.sample_tick = vt[i].tick;
      if1.clr_ovr = vt[i].clr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {14'd0, obs1}, {14'd0, vt[i].exp});
    end
    if1.sample_tick = 1'b0;
    if1.clr_ovr = 1'b0;

    // dut2 idle throughout the table (only reset activity)
    chk("s3_idle", {14'd0, obs2}, {14'd0, idw(0)});

    // T3: STEP_CYCLES=3, enables on the third cycle of each step, yk_valid at t+16
    if2.sample_tick = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if2.sample_tick = 1'b0;
        chk($sformatf("s3_step%0d_cyc%0d", n, c), {14'd0, obs2}, {14'd0, cw(n, c == 2, 1'b0)});
      end
    end
    @(posedge clk); #1;
    chk("s3_shift", {14'd0, obs2}, {14'd0, shw(0)});
    @(posedge clk); #1;
    chk("s3_idle_after", {14'd0, obs2}, {14'd0, idw(0)});

    // T2: datapath in the loop, y(k)=f(k-1) with these coefficients
    run_tick(100, 0);
    run_tick(200, 100);
    chk("dp_f1", f1, 200);
    chk("dp_f2", f2, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
